// File: rtl/types_pkg.sv
// Shared RV32 control-transfer encodings and the per-instruction branch result flags.
package types_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic taken;
        logic mispredict;
    } br_res_t;

endpackage

// File: rtl/rob_age_cmp.sv
// Flags a ROB tag that lies strictly younger than flush_tag and older than the tail,
// measured as wrap-safe distances from flush_tag.
module rob_age_cmp #(
    parameter int unsigned ROB_W = 5
) (
    input  logic [ROB_W-1:0] tag,
    input  logic [ROB_W-1:0] flush_tag,
    input  logic [ROB_W-1:0] curr_rob_tag,
    output logic             kill
);

    logic [ROB_W-1:0] age_tag;
    logic [ROB_W-1:0] age_tail;

    always_comb begin
        age_tag  = tag - flush_tag;
        age_tail = curr_rob_tag - flush_tag;
        kill     = (age_tag != '0) && (age_tag < age_tail);
    end

endmodule

// File: rtl/fu_branch_pipe.sv
// Pipelined branch/jump resolution unit: resolves at issue, then carries the result
// through STAGES elastic registers, discarding entries younger than a flushing branch.
module fu_branch_pipe
    import types_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned PREG_W = 7,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [PREG_W-1:0] pd,
    input  logic [ROB_W-1:0]  rob_index,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    input  logic [XLEN-1:0]   ps1_data,
    input  logic [XLEN-1:0]   ps2_data,
    input  logic [ROB_W-1:0]  curr_rob_tag,
    input  logic              flush,
    input  logic [ROB_W-1:0]  flush_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [PREG_W-1:0] out_pd,
    output logic [XLEN-1:0]   out_data,
    output logic [ROB_W-1:0]  out_rob,
    output logic              out_taken,
    output logic [XLEN-1:0]   out_target,
    output logic              out_mispredict,
    output logic [ROB_W-1:0]  out_mispredict_tag
);

    localparam int unsigned LAST = STAGES - 1;

    typedef struct packed {
        logic              we;
        logic [PREG_W-1:0] pd;
        logic [XLEN-1:0]   data;
        logic [ROB_W-1:0]  rob;
        logic [XLEN-1:0]   target;
        br_res_t           res;
    } stage_t;

    stage_t              pipe [STAGES];
    stage_t              stage_in;
    logic [STAGES-1:0]   valid;
    logic [STAGES-1:0]   valid_eff;
    logic [STAGES-1:0]   adv;
    logic [STAGES-1:0]   stage_kill;
    logic                issue_kill;
    logic                issue_fire;

    logic                eq_c;
    logic                lt_s_c;
    logic                lt_u_c;
    logic                taken_c;
    logic                jump_c;
    logic [XLEN-1:0]     link_c;
    logic [XLEN-1:0]     pc_imm_c;
    logic [XLEN-1:0]     jalr_sum_c;
    logic [XLEN-1:0]     target_c;

    // Resolve direction and next PC from the operands presented at issue.
    always_comb begin
        eq_c       = (ps1_data == ps2_data);
        lt_s_c     = ($signed(ps1_data) < $signed(ps2_data));
        lt_u_c     = (ps1_data < ps2_data);
        link_c     = pc + XLEN'(4);
        pc_imm_c   = pc + imm;
        jalr_sum_c = ps1_data + imm;
        taken_c    = 1'b0;
        jump_c     = 1'b0;
        target_c   = link_c;
        case (opcode)
            OPC_BRANCH: begin
                case (func3)
                    F3_BEQ:  taken_c = eq_c;
                    F3_BNE:  taken_c = !eq_c;
                    F3_BLT:  taken_c = lt_s_c;
                    F3_BGE:  taken_c = !lt_s_c;
                    F3_BLTU: taken_c = lt_u_c;
                    F3_BGEU: taken_c = !lt_u_c;
                    default: taken_c = 1'b0;
                endcase
                if (taken_c) target_c = pc_imm_c;
            end
            OPC_JAL: begin
                taken_c  = 1'b1;
                jump_c   = 1'b1;
                target_c = pc_imm_c;
            end
            OPC_JALR: begin
                taken_c  = 1'b1;
                jump_c   = 1'b1;
                target_c = {jalr_sum_c[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase

        stage_in.we             = jump_c && (pd != '0);
        stage_in.pd             = pd;
        stage_in.data           = link_c;
        stage_in.rob            = rob_index;
        stage_in.target         = target_c;
        stage_in.res.taken      = taken_c;
        stage_in.res.mispredict = (taken_c != pred_taken) || (taken_c && (target_c != pred_target));
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_kill
        rob_age_cmp #(.ROB_W(ROB_W)) u_cmp (
            .tag          (pipe[g].rob),
            .flush_tag    (flush_tag),
            .curr_rob_tag (curr_rob_tag),
            .kill         (stage_kill[g])
        );
    end

    rob_age_cmp #(.ROB_W(ROB_W)) u_issue_cmp (
        .tag          (rob_index),
        .flush_tag    (flush_tag),
        .curr_rob_tag (curr_rob_tag),
        .kill         (issue_kill)
    );

    // A stage may move when some stage at or beyond it is (effectively) empty, or the CDB takes the tail.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            valid_eff[i] = valid[i] && !(flush && stage_kill[i]);
            acc          = acc || !valid_eff[i];
            adv[i]       = acc;
        end
    end

    assign issue_ready = !valid[0] || adv[0];
    assign issue_fire  = issue_valid && issue_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            if (adv[0]) begin
                valid[0] <= issue_fire && !(flush && issue_kill);
                if (issue_fire) pipe[0] <= stage_in;
            end else begin
                valid[0] <= valid_eff[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    valid[i] <= valid_eff[i-1];
                    if (valid_eff[i-1]) pipe[i] <= pipe[i-1];
                end else begin
                    valid[i] <= valid_eff[i];
                end
            end
        end
    end

    // A tail entry killed this cycle must not be seen as a result or a redirect.
    assign out_valid          = valid_eff[LAST];
    assign out_we             = valid_eff[LAST] && pipe[LAST].we;
    assign out_pd             = pipe[LAST].pd;
    assign out_data           = pipe[LAST].data;
    assign out_rob            = pipe[LAST].rob;
    assign out_taken          = pipe[LAST].res.taken;
    assign out_target         = pipe[LAST].target;
    assign out_mispredict     = valid_eff[LAST] && pipe[LAST].res.mispredict;
    assign out_mispredict_tag = out_mispredict ? pipe[LAST].rob : '0;

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Directed and randomized check of fu_branch_pipe against an in-order queue model
// that applies the ROB flush window rule to every in-flight instruction.
module tb_fu_branch_pipe;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned PREG_W = 7;
    localparam int          STAGES = 2;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic              issue_ready;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_index;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic [XLEN-1:0]   ps1_data;
    logic [XLEN-1:0]   ps2_data;
    logic [ROB_W-1:0]  curr_rob_tag;
    logic              flush;
    logic [ROB_W-1:0]  flush_tag;
    logic              out_valid;
    logic              out_ready;
    logic              out_we;
    logic [PREG_W-1:0] out_pd;
    logic [XLEN-1:0]   out_data;
    logic [ROB_W-1:0]  out_rob;
    logic              out_taken;
    logic [XLEN-1:0]   out_target;
    logic              out_mispredict;
    logic [ROB_W-1:0]  out_mispredict_tag;

    fu_branch_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .func3(func3), .pc(pc), .imm(imm), .pd(pd), .rob_index(rob_index),
        .pred_taken(pred_taken), .pred_target(pred_target), .ps1_data(ps1_data),
        .ps2_data(ps2_data), .curr_rob_tag(curr_rob_tag), .flush(flush), .flush_tag(flush_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_pd(out_pd),
        .out_data(out_data), .out_rob(out_rob), .out_taken(out_taken), .out_target(out_target),
        .out_mispredict(out_mispredict), .out_mispredict_tag(out_mispredict_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              taken;
        logic              mp;
        logic              we;
        logic [XLEN-1:0]   target;
        logic [XLEN-1:0]   data;
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] pd;
        int                icyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    logic              obs_valid, obs_taken, obs_mp, obs_we, last_fire, saw_stall;
    logic [XLEN-1:0]   obs_target, obs_data;
    logic [ROB_W-1:0]  obs_mptag, obs_rob, last_out_rob, next_tag;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected result of the instruction currently on the issue inputs.
    function automatic exp_t predict();
        exp_t e;
        logic [XLEN-1:0] s;
        e.we = 1'b0;
        e.taken = 1'b0;
        e.target = pc + 32'd4;
        if (opcode == 7'b1100011) begin
            case (func3)
                3'd0: e.taken = (ps1_data == ps2_data);
                3'd1: e.taken = (ps1_data != ps2_data);
                3'd4: e.taken = ($signed(ps1_data) <  $signed(ps2_data));
                3'd5: e.taken = ($signed(ps1_data) >= $signed(ps2_data));
                3'd6: e.taken = (ps1_data <  ps2_data);
                3'd7: e.taken = (ps1_data >= ps2_data);
                default: e.taken = 1'b0;
            endcase
            if (e.taken) e.target = pc + imm;
        end else if (opcode == 7'b1101111) begin
            e.taken = 1'b1;
            e.target = pc + imm;
            e.we = (pd != 0);
        end else if (opcode == 7'b1100111) begin
            e.taken = 1'b1;
            s = ps1_data + imm;
            s[0] = 1'b0;
            e.target = s;
            e.we = (pd != 0);
        end
        e.mp   = (e.taken != pred_taken) || (e.taken && (e.target != pred_target));
        e.data = pc + 32'd4;
        e.rob  = rob_index;
        e.pd   = pd;
        e.icyc = cyc;
        return e;
    endfunction

    // True when t is one of the tags allocated after flush_tag and before the tail.
    function automatic logic younger(input logic [ROB_W-1:0] t);
        logic [ROB_W-1:0] w;
        w = flush_tag + 5'd1;
        for (int k = 0; k < 32; k++) begin
            if (w == curr_rob_tag) return 1'b0;
            if (w == t) return 1'b1;
            w = w + 5'd1;
        end
        return 1'b0;
    endfunction

    // One clock: observe just before the rising edge, update the model, return at the falling edge.
    task automatic step(input logic tchk);
        int qs;
        exp_t e;
        #4;
        qs = q.size();
        if (!flush) chk("issue_ready", 64'(issue_ready), 64'((qs < STAGES) || out_ready));
        if (issue_valid && !issue_ready) saw_stall = 1'b1;
        if (flush) begin
            for (int i = q.size() - 1; i >= 0; i--) if (younger(q[i].rob)) q.delete(i);
        end
        obs_valid = out_valid; obs_taken = out_taken; obs_target = out_target; obs_mp = out_mispredict;
        obs_mptag = out_mispredict_tag; obs_we = out_we; obs_data = out_data; obs_rob = out_rob;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = q[0];
                chk("early_out", 64'(cyc - e.icyc >= STAGES), 64'(1));
                chk("rob", 64'(out_rob), 64'(e.rob));
                chk("taken", 64'(out_taken), 64'(e.taken));
                chk("target", 64'(out_target), 64'(e.target));
                chk("mispredict", 64'(out_mispredict), 64'(e.mp));
                chk("mp_tag", 64'(out_mispredict_tag), e.mp ? 64'(e.rob) : 64'(0));
                chk("we", 64'(out_we), 64'(e.we));
                if (e.we) begin
                    chk("pd", 64'(out_pd), 64'(e.pd));
                    chk("link", 64'(out_data), 64'(e.data));
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                    last_out_rob = out_rob;
                end
            end
        end else if (tchk && q.size() > 0 && (cyc - q[0].icyc >= STAGES)) begin
            chk("late_out", 64'(out_valid), 64'(1));
        end
        last_fire = issue_valid && issue_ready;
        if (last_fire && !(flush && younger(rob_index))) q.push_back(predict());
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic [XLEN-1:0] p,
                             input logic [XLEN-1:0] im, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [PREG_W-1:0] d, input logic [ROB_W-1:0] r,
                             input logic pt, input logic [XLEN-1:0] ptg);
        issue_valid = 1'b1; opcode = op; func3 = f3; pc = p; imm = im; ps1_data = a; ps2_data = b;
        pd = d; rob_index = r; pred_taken = pt; pred_target = ptg;
    endtask

    task automatic rand_issue(input logic [ROB_W-1:0] r);
        int sel;
        exp_t e;
        sel = int'($urandom_range(0, 9));
        issue_valid = ($urandom_range(0, 3) != 0);
        opcode = (sel < 6) ? 7'b1100011 : (sel == 6) ? 7'b1101111 : (sel < 9) ? 7'b1100111 : 7'b0110011;
        func3 = 3'($urandom);
        pc = {$urandom, 2'b00} >> 2 << 2;
        imm = (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : 32'(-$urandom_range(1, 4096)));
        ps1_data = $urandom;
        case ($urandom_range(0, 2))
            0: ps2_data = ps1_data;
            1: ps2_data = 32'($urandom_range(0, 3)) - 32'd1;
            default: ps2_data = $urandom;
        endcase
        pd = 7'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        rob_index = r;
        pred_taken = 1'($urandom);
        pred_target = $urandom;
        e = predict();
        if ($urandom_range(0, 1) == 1) pred_target = e.target;
    endtask

    initial begin
        reset = 1'b0; issue_valid = 1'b0; opcode = '0; func3 = '0; pc = '0; imm = '0; pd = '0;
        rob_index = '0; pred_taken = 1'b0; pred_target = '0; ps1_data = '0; ps2_data = '0;
        curr_rob_tag = 5'd10; flush = 1'b0; flush_tag = '0; out_ready = 1'b1;
        saw_stall = 1'b0; last_out_rob = '0; next_tag = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_issue_ready", 64'(issue_ready), 64'(1));
        chk("rst_target", 64'(out_target), 64'(0));
        chk("rst_mispredict", 64'(out_mispredict), 64'(0));
        chk("rst_we", 64'(out_we), 64'(0));
        reset = 1'b1;

        // BEQ taken against a not-taken prediction.
        set_issue(7'b1100011, 3'd0, 32'd1000, 32'd64, 32'd7, 32'd7, 7'd0, 5'd4, 1'b0, 32'd0);
        step(1'b1);
        issue_valid = 1'b0;
        step(1'b1);
        chk("t1_not_yet", 64'(obs_valid), 64'(0));
        step(1'b1);
        chk("t1_valid", 64'(obs_valid), 64'(1));
        chk("t1_taken", 64'(obs_taken), 64'(1));
        chk("t1_target", 64'(obs_target), 64'(1064));
        chk("t1_mp", 64'(obs_mp), 64'(1));
        chk("t1_mptag", 64'(obs_mptag), 64'(4));

        // Signed versus unsigned compare on the same operands.
        set_issue(7'b1100011, 3'd4, 32'd3000, 32'd100, 32'hFFFF_FFFF, 32'd1, 7'd0, 5'd5, 1'b0, 32'd0);
        step(1'b1);
        set_issue(7'b1100011, 3'd6, 32'd3000, 32'd100, 32'hFFFF_FFFF, 32'd1, 7'd0, 5'd6, 1'b0, 32'd0);
        step(1'b1);
        issue_valid = 1'b0;
        step(1'b1);
        chk("t2_blt_taken", 64'(obs_taken), 64'(1));
        chk("t2_blt_mp", 64'(obs_mp), 64'(1));
        step(1'b1);
        chk("t2_bltu_taken", 64'(obs_taken), 64'(0));
        chk("t2_bltu_target", 64'(obs_target), 64'(3004));
        chk("t2_bltu_mp", 64'(obs_mp), 64'(0));

        // JALR with a correct prediction, then with x0 as destination.
        set_issue(7'b1100111, 3'd0, 32'd2000, 32'd20, 32'd501, 32'd0, 7'd9, 5'd7, 1'b1, 32'd520);
        step(1'b1);
        set_issue(7'b1100111, 3'd0, 32'd2000, 32'd20, 32'd501, 32'd0, 7'd0, 5'd8, 1'b1, 32'd520);
        step(1'b1);
        issue_valid = 1'b0;
        step(1'b1);
        chk("t3_target", 64'(obs_target), 64'(520));
        chk("t3_link", 64'(obs_data), 64'(2004));
        chk("t3_we", 64'(obs_we), 64'(1));
        chk("t3_mp", 64'(obs_mp), 64'(0));
        step(1'b1);
        chk("t3_we_x0", 64'(obs_we), 64'(0));

        // Four back-to-back issues against a stalled CDB.
        out_ready = 1'b0; saw_stall = 1'b0; n_out = 0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 30 && (k < 4 || q.size() > 0); c++) begin
                if (c == 3) out_ready = 1'b1;
                if (k < 4) set_issue(7'b1101111, 3'd0, 32'(4000 + 16 * k), 32'd8, 32'd0, 32'd0,
                                     7'(k + 1), 5'(10 + k), 1'b1, 32'(4008 + 16 * k));
                else issue_valid = 1'b0;
                step(1'b1);
                if (last_fire) k++;
            end
        end
        issue_valid = 1'b0;
        chk("t4_stall_seen", 64'(saw_stall), 64'(1));
        chk("t4_count", 64'(n_out), 64'(4));

        // Wrapped flush window: 31 and 0 die, 30 survives.
        out_ready = 1'b0; curr_rob_tag = 5'd2; n_out = 0;
        set_issue(7'b1100011, 3'd1, 32'd100, 32'd8, 32'd1, 32'd2, 7'd0, 5'd30, 1'b1, 32'd108);
        step(1'b1);
        rob_index = 5'd31;
        step(1'b1);
        rob_index = 5'd0; flush = 1'b1; flush_tag = 5'd30;
        step(1'b0);
        flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step(1'b1);
        chk("t5_count", 64'(n_out), 64'(1));
        chk("t5_survivor", 64'(last_out_rob), 64'(30));

        // Flush coinciding with the output handshake: younger dies, flush_tag's own entry leaves.
        curr_rob_tag = 5'd8;
        set_issue(7'b1101111, 3'd0, 32'd500, 32'd4, 32'd0, 32'd0, 7'd3, 5'd5, 1'b0, 32'd0);
        step(1'b1);
        issue_valid = 1'b0;
        step(1'b1);
        flush = 1'b1; flush_tag = 5'd3;
        step(1'b0);
        chk("t5b_killed_at_out", 64'(obs_valid), 64'(0));
        flush = 1'b0;
        set_issue(7'b1101111, 3'd0, 32'd500, 32'd4, 32'd0, 32'd0, 7'd3, 5'd3, 1'b0, 32'd0);
        step(1'b1);
        issue_valid = 1'b0;
        step(1'b1);
        flush = 1'b1;
        step(1'b0);
        chk("t5b_own_tag", 64'(obs_valid), 64'(1));
        chk("t5b_own_rob", 64'(obs_rob), 64'(3));
        flush = 1'b0;

        // Reset with two entries in flight.
        out_ready = 1'b0;
        set_issue(7'b1100011, 3'd0, 32'd60, 32'd8, 32'd1, 32'd1, 7'd0, 5'd1, 1'b0, 32'd0);
        step(1'b1);
        rob_index = 5'd2;
        step(1'b1);
        issue_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_issue_ready", 64'(issue_ready), 64'(1));
        q.delete();
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        set_issue(7'b1100011, 3'd1, 32'd80, 32'd12, 32'd1, 32'd0, 7'd0, 5'd9, 1'b0, 32'd0);
        step(1'b1);
        issue_valid = 1'b0;
        repeat (STAGES - 1) step(1'b1);
        chk("t6_bne_valid", 64'(obs_valid), 64'(0));
        step(1'b1);
        chk("t6_bne_valid", 64'(obs_valid), 64'(1));
        chk("t6_bne_taken", 64'(obs_taken), 64'(1));
        chk("t6_bne_target", 64'(obs_target), 64'(92));

        // Random traffic with backpressure, no flush: exact timing is checked.
        for (int c = 0; c < 600; c++) begin
            rand_issue(5'($urandom));
            curr_rob_tag = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1'b1);
        end

        // Random traffic with flushes over an in-order tag stream.
        next_tag = 5'd0;
        for (int c = 0; c < 1500; c++) begin
            rand_issue(next_tag);
            curr_rob_tag = next_tag + 5'($urandom_range(1, 3));
            flush = ($urandom_range(0, 7) == 0);
            flush_tag = next_tag - 5'($urandom_range(1, 4));
            out_ready = ($urandom_range(0, 3) != 0);
            step(1'b0);
            if (last_fire) next_tag = next_tag + 5'd1;
        end

        issue_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) step(1'b0);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fu_branch_pipe.md
Name: fu_branch_pipe

Overview:
- Parametrised, pipelined successor to the combinational branch FU.
- Resolves all RV32 B-type branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR against a front-end prediction.
- Sits between the branch RS/PRF read and the CDB/ROB, with a valid/ready elastic pipeline of configurable depth.
- Discards in-flight work younger than an external mispredict tag, with ROB wrap-around handled.

Parameters:
- XLEN, 32, data/PC width
- ROB_W, 5, ROB tag width (ROB depth 2^ROB_W)
- PREG_W, 7, physical register tag width
- STAGES, 2, pipeline depth 1..3; 1 means a single output register

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  RS presents an instruction
- issue_ready  out  1  FU accepts this cycle
- opcode  in  7  instruction opcode
- func3  in  3  branch condition
- pc  in  XLEN  instruction PC
- imm  in  XLEN  sign-extended immediate
- pd  in  PREG_W  destination preg (jumps only)
- rob_index  in  ROB_W  ROB tag of the instruction
- pred_taken  in  1  front-end predicted taken
- pred_target  in  XLEN  front-end predicted target
- ps1_data  in  XLEN  rs1 value
- ps2_data  in  XLEN  rs2 value
- curr_rob_tag  in  ROB_W  ROB tail (next tag to allocate)
- flush  in  1  older mispredict being recovered
- flush_tag  in  ROB_W  tag of the mispredicting branch
- out_valid  out  1  result valid
- out_ready  in  1  CDB accepts the result
- out_we  out  1  writes out_pd (JAL/JALR with pd != 0)
- out_pd  out  PREG_W  destination preg
- out_data  out  XLEN  link value pc+4
- out_rob  out  ROB_W  ROB tag
- out_taken  out  1  resolved direction
- out_target  out  XLEN  correct next PC
- out_mispredict  out  1  redirect required
- out_mispredict_tag  out  ROB_W  equals out_rob when out_mispredict is 1, else 0

Behaviour:
- Reset: all stage valid bits 0. All outputs 0 except issue_ready = 1.
- Handshake: a transfer occurs when valid && ready. issue_ready = !stage0_valid || stage0_advances.
- Each stage advances when its successor is empty or advances. The last stage advances on out_ready.
- Latency: exactly STAGES cycles from issue to out_valid with out_ready held high. Throughput is 1 per cycle.
- Resolution is combinational at issue, and the result is registered into stage 0.
- Direction:
  - BEQ: eq. BNE: !eq.
  - BLT/BGE: signed compare. BLTU/BGEU: unsigned compare.
  - func3 010/011 on B-type: not taken.
  - JAL/JALR: always taken.
  - Any other opcode: accepted, not taken, out_we = 0.
- Target:
  - B-type and JAL: pc+imm.
  - JALR: (ps1+imm) & ~1.
  - Not taken: pc+4.
  - All sums are modulo 2^XLEN.
- Mispredict = (taken != pred_taken) || (taken && target != pred_target).
- Output fields are held stable while out_valid && !out_ready.
- Flush:
  - Define age(x) = (x - flush_tag) mod 2^ROB_W.
  - An entry is killed when 0 < age(rob) < age(curr_rob_tag). This is evaluated per stage, each cycle flush = 1.
  - A killed stage clears its valid bit at the next edge and never produces out_valid.
  - An issue presented during flush with a matching tag is accepted and dropped.
- flush_tag's own entry and entries older than it survive.
- flush and an output handshake in the same cycle: a matching last-stage entry is killed, so no result and no mispredict is emitted.
- A ROB window that wraps (e.g. flush_tag = 30, curr_rob_tag = 2) kills tags 31, 0 and 1.
- Reset asserted mid-operation clears all stages immediately (asynchronously). In-flight results are lost.

Decomposition:
- types_pkg gains:
  - OPC_BRANCH / OPC_JAL / OPC_JALR constants
  - the F3_BEQ..F3_BGEU func3 constants
  - a parametrised-width-free br_res_t struct holding the taken/mispredict flags
- Sub-module rob_age_cmp:
  - purely combinational
  - parameter ROB_W
  - inputs tag, flush_tag, curr_rob_tag
  - output kill
  - instantiated once per stage plus once on the issue path

Test Plan:
- Test 1, BEQ resolve (STAGES = 2):
  - Stimulus: pc = 1000, imm = 64, ps1 = ps2 = 7, pred_taken = 0, rob = 4.
  - Response: out_valid 2 cycles later; taken = 1, target = 1064, mispredict = 1, mispredict_tag = 4.
- Test 2, BLT vs BLTU:
  - Stimulus: ps1 = 0xFFFFFFFF, ps2 = 1.
  - Response: BLT taken = 1; BLTU taken = 0, target = pc+4. With pred_taken = 0, mispredict is 1 for BLT and 0 for BLTU.
- Test 3, JALR:
  - Stimulus: pc = 2000, ps1 = 501, imm = 20, pd = 9, pred_taken = 1, pred_target = 520.
  - Response: target = 520, out_data = 2004, out_we = 1, mispredict = 0. A variant with pd = 0 gives out_we = 0.
- Test 4, backpressure:
  - Stimulus: 4 back-to-back issues with out_ready = 0 for 3 cycles.
  - Response: issue_ready drops once the pipeline is full; results emerge in order with fields stable; no loss or duplication.
- Test 5, wrapped flush:
  - Stimulus: in-flight tags 30, 31, 0; flush = 1, flush_tag = 30, curr_rob_tag = 2.
  - Response: tags 31 and 0 are killed; tag 30 emerges normally.
- Test 6, reset mid-flight:
  - Stimulus: drive reset = 0 with 2 entries valid.
  - Response: out_valid = 0 immediately and issue_ready = 1. After release, a new BNE with ps1 = 1, ps2 = 0 resolves taken after STAGES cycles.
